// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - two-requester round-robin front end for a shared combinational ALU
module alu_arbiter #(
    parameter int WIDTH  = 16,
    parameter int SETTLE = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0,
    input  logic             req1,
    input  logic [WIDTH-1:0] a0,
    input  logic [WIDTH-1:0] b0,
    input  logic [WIDTH-1:0] a1,
    input  logic [WIDTH-1:0] b1,
    input  logic [1:0]       fun0,
    input  logic [1:0]       fun1,
    output logic             gnt0,
    output logic             gnt1,
    output logic             done0,
    output logic             done1,
    output logic [WIDTH-1:0] z_out,
    output logic             busy,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [1:0]       alu_fun,
    input  logic [WIDTH-1:0] alu_z
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Settle counter starts one below SETTLE so capture lands exactly SETTLE edges after accept.
    localparam logic [3:0] CNT_INIT = 4'(SETTLE - 1);

    state_t           state, state_n;
    logic [3:0]       cnt, cnt_n;
    logic             owner, owner_n;
    logic             last, last_n;
    logic             win;
    logic             gnt0_n, gnt1_n, done0_n, done1_n;
    logic [WIDTH-1:0] z_n, alu_a_n, alu_b_n;
    logic [1:0]       alu_fun_n;

    // Next-state, arbitration and registered-output computation.
    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        owner_n   = owner;
        last_n    = last;
        win       = 1'b0;
        gnt0_n    = 1'b0;
        gnt1_n    = 1'b0;
        done0_n   = 1'b0;
        done1_n   = 1'b0;
        z_n       = z_out;
        alu_a_n   = alu_a;
        alu_b_n   = alu_b;
        alu_fun_n = alu_fun;
        case (state)
            S_IDLE: begin
                if (req0 || req1) begin
                    // On a tie the requester not granted last wins; a lone request always wins.
                    win       = (req0 && req1) ? ~last : req1;
                    owner_n   = win;
                    last_n    = win;
                    alu_a_n   = win ? a1 : a0;
                    alu_b_n   = win ? b1 : b0;
                    alu_fun_n = win ? fun1 : fun0;
                    gnt0_n    = ~win;
                    gnt1_n    = win;
                    cnt_n     = CNT_INIT;
                    state_n   = S_EXEC;
                end
            end
            S_EXEC: begin
                if (cnt != 4'd0) begin
                    cnt_n = cnt - 4'd1;
                end else begin
                    z_n     = alu_z;
                    done0_n = ~owner;
                    done1_n = owner;
                    state_n = S_DONE;
                end
            end
            S_DONE: begin
                state_n = S_IDLE;
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    // State and output registers; reset discards any in-flight operation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            cnt     <= 4'd0;
            owner   <= 1'b0;
            last    <= 1'b1;
            gnt0    <= 1'b0;
            gnt1    <= 1'b0;
            done0   <= 1'b0;
            done1   <= 1'b0;
            z_out   <= '0;
            alu_a   <= '0;
            alu_b   <= '0;
            alu_fun <= 2'b00;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            owner   <= owner_n;
            last    <= last_n;
            gnt0    <= gnt0_n;
            gnt1    <= gnt1_n;
            done0   <= done0_n;
            done1   <= done1_n;
            z_out   <= z_n;
            alu_a   <= alu_a_n;
            alu_b   <= alu_b_n;
            alu_fun <= alu_fun_n;
        end
    end

    assign busy = (state != S_IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - randomized self-checking bench for alu_arbiter against a transaction-timeline model
module tb_alu_arbiter;

    localparam int S_MAIN = 1;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req0 = 1'b0, req1 = 1'b0;
    logic [15:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
    logic [1:0]  fun0 = '0, fun1 = '0;
    logic        gnt0, gnt1, done0, done1, busy;
    logic [15:0] z_out, alu_a, alu_b, alu_z;
    logic [1:0]  alu_fun;

    logic        q_req1 = 1'b0;
    logic [15:0] q_a1 = '0, q_b1 = '0;
    logic        q_gnt0, q_gnt1, q_done0, q_done1, q_busy;
    logic [15:0] q_z_out, q_alu_a, q_alu_b, q_alu_z;
    logic [1:0]  q_alu_fun;
    logic        q_req0 = 1'b0;
    logic [15:0] q_zero16 = '0;
    logic [1:0]  q_zero2 = '0;

    assign alu_z   = alu_a + alu_b;
    assign q_alu_z = q_alu_a + q_alu_b;

    always #5 clk = ~clk;

    alu_arbiter #(.WIDTH(16), .SETTLE(S_MAIN)) dut (
        .clk(clk), .rst_n(rst_n), .req0(req0), .req1(req1),
        .a0(a0), .b0(b0), .a1(a1), .b1(b1), .fun0(fun0), .fun1(fun1),
        .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
        .z_out(z_out), .busy(busy), .alu_a(alu_a), .alu_b(alu_b),
        .alu_fun(alu_fun), .alu_z(alu_z)
    );

    alu_arbiter #(.WIDTH(16), .SETTLE(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .req0(q_req0), .req1(q_req1),
        .a0(q_zero16), .b0(q_zero16), .a1(q_a1), .b1(q_b1), .fun0(q_zero2), .fun1(q_zero2),
        .gnt0(q_gnt0), .gnt1(q_gnt1), .done0(q_done0), .done1(q_done1),
        .z_out(q_z_out), .busy(q_busy), .alu_a(q_alu_a), .alu_b(q_alu_b),
        .alu_fun(q_alu_fun), .alu_z(q_alu_z)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Transaction-timeline model: each accepted operation is described by its accept edge.
    int          k;
    int          acc_edge;
    int          free_edge;
    bit          m_owner, m_last;
    logic [15:0] m_a, m_b, m_z;
    logic [1:0]  m_fun;
    bit          e_gnt0, e_gnt1, e_done0, e_done1, e_busy;

    task automatic model_reset();
        k = 0; acc_edge = -1000; free_edge = 0;
        m_owner = 1'b0; m_last = 1'b1;
        m_a = '0; m_b = '0; m_z = '0; m_fun = '0;
    endtask

    task automatic model_update();
        bit w;
        k++;
        if (k >= free_edge && (req0 || req1)) begin
            w = (req0 && req1) ? !m_last : bit'(req1);
            m_last = w; m_owner = w;
            m_a = w ? a1 : a0; m_b = w ? b1 : b0; m_fun = w ? fun1 : fun0;
            acc_edge = k;
            free_edge = k + S_MAIN + 2;
        end
        if (k == acc_edge + S_MAIN) m_z = m_a + m_b;
    endtask

    task automatic model_check();
        e_gnt0  = (k == acc_edge) && !m_owner;
        e_gnt1  = (k == acc_edge) && m_owner;
        e_done0 = (k == acc_edge + S_MAIN) && !m_owner;
        e_done1 = (k == acc_edge + S_MAIN) && m_owner;
        e_busy  = (k >= acc_edge) && (k <= acc_edge + S_MAIN);
        check("gnt0", 32'(gnt0), 32'(e_gnt0));
        check("gnt1", 32'(gnt1), 32'(e_gnt1));
        check("done0", 32'(done0), 32'(e_done0));
        check("done1", 32'(done1), 32'(e_done1));
        check("busy", 32'(busy), 32'(e_busy));
        check("z_out", 32'(z_out), 32'(m_z));
        check("alu_a", 32'(alu_a), 32'(m_a));
        check("alu_b", 32'(alu_b), 32'(m_b));
        check("alu_fun", 32'(alu_fun), 32'(m_fun));
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        @(negedge clk);
        model_check();
    endtask

    int          g_k[$];
    bit          g_o[$];
    bit          first_exp;
    int          kg0, kg1, cyc;
    bit          seen;

    initial begin
        model_reset();
        repeat (3) @(negedge clk);
        check("rst_gnt0", 32'(gnt0), 32'd0);
        check("rst_done1", 32'(done1), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_z", 32'(z_out), 32'd0);
        check("rst_alu_a", 32'(alu_a), 32'd0);
        check("rst_alu_fun", 32'(alu_fun), 32'd0);
        rst_n = 1'b1;
        model_reset();

        // Single REQ0 operation.
        req0 = 1'b1; a0 = 16'h000B; b0 = 16'h0269; fun0 = 2'b01;
        step();
        check("t1_gnt0", 32'(gnt0), 32'd1);
        check("t1_alu_a", 32'(alu_a), 32'h000B);
        check("t1_alu_fun", 32'(alu_fun), 32'h1);
        req0 = 1'b0;
        step();
        check("t1_done0", 32'(done0), 32'd1);
        check("t1_z", 32'(z_out), 32'h0274);
        step();
        check("t1_busy", 32'(busy), 32'd0);
        repeat (2) step();

        // Both requesters held high: grants alternate every SETTLE+2 cycles.
        req0 = 1'b1; a0 = 16'h1234; b0 = 16'h1111; fun0 = 2'b10;
        req1 = 1'b1; a1 = 16'h8000; b1 = 16'h8001; fun1 = 2'b11;
        first_exp = !m_last;
        for (int i = 0; i < 13; i++) begin
            step();
            if (gnt0 || gnt1) begin
                g_k.push_back(k);
                g_o.push_back(gnt1);
            end
        end
        check("t2_ngrants", 32'(g_k.size()), 32'd5);
        for (int i = 0; i < g_o.size(); i++) begin
            check("t2_owner", 32'(g_o[i]), 32'(first_exp ^ bit'(i % 2)));
            if (i > 0) check("t2_gap", 32'(g_k[i] - g_k[i-1]), 32'(S_MAIN + 2));
        end
        req0 = 1'b0; req1 = 1'b0;
        repeat (3) step();

        // REQ1 raised while busy with a REQ0 operation.
        kg0 = -1; kg1 = -1;
        req0 = 1'b1; a0 = 16'h0F0F; b0 = 16'h00F1;
        step();
        if (gnt0) kg0 = k;
        req0 = 1'b0; req1 = 1'b1; a1 = 16'h4000; b1 = 16'h0044;
        for (int i = 0; i < 6; i++) begin
            step();
            if (gnt1 && kg1 < 0) begin
                kg1 = k;
                req1 = 1'b0;
            end
        end
        check("t4_gnt0_seen", 32'(kg0 >= 0), 32'd1);
        check("t4_gnt1_delay", 32'(kg1 - kg0), 32'(S_MAIN + 2));

        // Asynchronous reset in the middle of an operation.
        req0 = 1'b1; a0 = 16'h0055; b0 = 16'h0066; fun0 = 2'b11;
        step();
        req0 = 1'b0;
        rst_n = 1'b0;
        #1;
        check("ar_gnt0", 32'(gnt0), 32'd0);
        check("ar_busy", 32'(busy), 32'd0);
        check("ar_alu_a", 32'(alu_a), 32'd0);
        check("ar_alu_fun", 32'(alu_fun), 32'd0);
        check("ar_z", 32'(z_out), 32'd0);
        @(posedge clk);
        #1;
        check("ar_done0", 32'(done0), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        req0 = 1'b1; req1 = 1'b1;
        a0 = 16'h7000; b0 = 16'h0007; a1 = 16'h0101; b1 = 16'h0202;
        step();
        check("ar_tie_gnt0", 32'(gnt0), 32'd1);
        req0 = 1'b0;
        repeat (3) step();
        req1 = 1'b0;
        repeat (3) step();

        // Random traffic; requesters hold until granted, then drop or re-request.
        for (int i = 0; i < 600; i++) begin
            if (req0 && e_gnt0) begin
                if ($urandom_range(0, 3) == 0) begin
                    a0 = 16'($urandom); b0 = 16'($urandom); fun0 = 2'($urandom);
                end else req0 = 1'b0;
            end else if (!req0 && $urandom_range(0, 2) == 0) begin
                req0 = 1'b1;
                a0 = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
                b0 = 16'($urandom); fun0 = 2'($urandom);
            end
            if (req1 && e_gnt1) begin
                if ($urandom_range(0, 3) == 0) begin
                    a1 = 16'($urandom); b1 = 16'($urandom); fun1 = 2'($urandom);
                end else req1 = 1'b0;
            end else if (!req1 && $urandom_range(0, 2) == 0) begin
                req1 = 1'b1;
                a1 = 16'($urandom);
                b1 = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
                fun1 = 2'($urandom);
            end
            step();
        end
        req0 = 1'b0; req1 = 1'b0;

        // SETTLE=4 instance: wrap-around sum, DONE four cycles after GNT.
        q_req1 = 1'b1; q_a1 = 16'hFFFF; q_b1 = 16'h0002;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            if (q_gnt1) seen = 1'b1;
        end
        check("s4_gnt1_seen", 32'(seen), 32'd1);
        q_req1 = 1'b0;
        check("s4_alu_a", 32'(q_alu_a), 32'hFFFF);
        cyc = 0; seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            cyc++;
            if (q_done1) seen = 1'b1;
        end
        check("s4_done1_seen", 32'(seen), 32'd1);
        check("s4_done_delay", 32'(cyc), 32'd4);
        check("s4_z", 32'(q_z_out), 32'h0001);
        check("s4_done0", 32'(q_done0), 32'd0);
        @(negedge clk);
        check("s4_busy_after", 32'(q_busy), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
